garage_door_ctrl: RTL and testbench
===================================

Name: garage_door_ctrl

Overview:
- Parametrised garage door motor controller; successor to the basic three-state up/down door FSM.
- Adds edge-detected Activate, mid-travel stop, and reversal of a closing door on obstruction.
- Adds a travel watchdog with fault latch and direction memory for doors stopped between limits.
- Sits between the debounced door sensors/push-button and the motor driver; all outputs are decoded from registered state.

Parameters:
- TRAVEL_MAX, 1000: max clock cycles allowed in one motion state before FAULT.
- AUTO_CLOSE, 5000: cycles a fully-open idle door waits before auto-closing (used only when GDC_AUTO_CLOSE_EN is defined).
- CNT_W, 16: width of the shared cycle counter; must hold max(TRAVEL_MAX, AUTO_CLOSE).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous reset, active-low.
- Activate  input  1  push-button level, synchronous/debounced upstream.
- UP_Max  input  1  door fully open limit switch.
- DN_Max  input  1  door fully closed limit switch.
- Obstruct  input  1  beam-break sensor, high = obstruction.
- UP_M  output  1  motor up drive.
- DN_M  output  1  motor down drive.
- FAULT  output  1  watchdog/sensor fault flag.
- STATE  output  2  current state code, for debug/status.

Behaviour:
- States and codes: IDLE=0, MV_UP=1, MV_DN=2, FLT=3. Encoding is fixed.
- Reset (RST=0, async): state=IDLE, counter=0, act_q=0, last_dir=DOWN.
  - All outputs are 0 in reset: UP_M=0, DN_M=0, FAULT=0, STATE=0.
- Activate edge: act_edge = Activate & ~act_q, where act_q is Activate registered each CLK.
  - A held button gives exactly one edge.
  - The state transition happens at the same CLK edge that samples act_edge=1.
- Outputs (Moore): UP_M=1 only in MV_UP; DN_M=1 only in MV_DN; FAULT=1 only in FLT; STATE = state code.
- Global sensor error: UP_Max & DN_Max both 1 -> FLT from any state. This has top priority, below reset.
- IDLE, on act_edge:
  - DN_Max=1 -> MV_UP.
  - UP_Max=1 -> MV_DN.
  - Neither limit active -> direction opposite to last_dir.
  - No act_edge -> stay in IDLE.
- MV_UP, priority order:
  - UP_Max -> IDLE.
  - act_edge -> IDLE (stop mid-travel).
  - counter == TRAVEL_MAX-1 -> FLT.
  - Otherwise stay.
  - Obstruct is ignored while opening.
- MV_DN, priority order:
  - DN_Max -> IDLE.
  - Obstruct -> MV_UP (reverse; counter restarts).
  - act_edge -> IDLE.
  - counter == TRAVEL_MAX-1 -> FLT.
  - Otherwise stay.
- last_dir: set to UP on entry to MV_UP, DOWN on entry to MV_DN. It is held in all other states.
- Counter:
  - Cleared on every state change.
  - Increments by 1 each cycle in MV_UP/MV_DN, and in IDLE when auto-close is active.
  - Otherwise held at 0. Saturates and never wraps.
- FLT: motors off. act_edge with UP_Max & DN_Max not both high -> IDLE. Otherwise remain in FLT.
- Reset asserted mid-motion drops both motor outputs immediately (async), regardless of CLK.

Optional Feature:
- Macro: GDC_AUTO_CLOSE_EN.
- Defined:
  - In IDLE with UP_Max=1 and Obstruct=0, the counter runs.
  - At counter == AUTO_CLOSE-1 -> MV_DN.
  - Obstruct=1 or act_edge clears the counter; act_edge still takes the normal IDLE transition.
- Undefined:
  - No auto-close logic; the counter is 0 in IDLE.
  - An open door stays in IDLE indefinitely.

Test Plan:
- Reset then DN_Max=1, Activate 0->1 held 10 cycles -> UP_M=1 starting the next cycle, and exactly one transition.
  - Then UP_Max=1 -> IDLE, UP_M=0, STATE=0.
- TRAVEL_MAX=20, UP_Max=1, activate, no limit reached -> DN_M high for 20 cycles, then FAULT=1, STATE=3.
  - Next act_edge -> IDLE, FAULT=0.
- In MV_DN at cycle 5, Obstruct=1 for 1 cycle -> STATE=1, UP_M=1, DN_M=0; counter restarts at 0.
- Mid-travel MV_UP, act_edge -> IDLE with both limits 0; next act_edge -> MV_DN (last_dir was UP).
- UP_Max=1 and DN_Max=1 together during MV_UP -> FLT next edge. RST=0 asynchronously mid-MV_DN -> DN_M=0 before the next CLK.
- With GDC_AUTO_CLOSE_EN and AUTO_CLOSE=50: open door idle -> DN_M=1 after 50 cycles.
  - Obstruct pulse at cycle 30 -> count restarts, close happens 50 cycles after the pulse.

Source files
------------

// File: rtl/garage_door_ctrl.sv
// garage_door_ctrl
//   Garage door motor controller. It has an edge-detected push-button and can
//   stop the door mid-travel. A closing door reverses when the beam is broken.
//   A travel watchdog latches FAULT, and the controller remembers the last
//   direction so a door stopped between the limits moves the other way next.
//   All outputs are decoded from registered state.
//
//   Optional feature: define GDC_AUTO_CLOSE_EN to let a fully-open, idle,
//   unobstructed door close by itself after AUTO_CLOSE cycles.
//
// Ports
//   CLK       system clock, rising edge
//   RST       asynchronous reset, active-low
//   Activate  push-button level (debounced upstream)
//   UP_Max    fully-open limit switch
//   DN_Max    fully-closed limit switch
//   Obstruct  beam-break sensor, high = obstruction
//   UP_M      motor up drive
//   DN_M      motor down drive
//   FAULT     watchdog / sensor fault flag
//   STATE     current state code
//
// state  | meaning
// IDLE   | motor off, door at a limit or stopped mid-travel
// MV_UP  | opening
// MV_DN  | closing
// FLT    | watchdog expired or both limits active; motors off

module garage_door_ctrl #(
    parameter int TRAVEL_MAX = 1000,
    parameter int AUTO_CLOSE = 5000,
    parameter int CNT_W      = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Activate,
    input  logic       UP_Max,
    input  logic       DN_Max,
    input  logic       Obstruct,
    output logic       UP_M,
    output logic       DN_M,
    output logic       FAULT,
    output logic [1:0] STATE
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MV_UP = 2'd1,
        MV_DN = 2'd2,
        FLT   = 2'd3
    } state_t;

`ifdef GDC_AUTO_CLOSE_EN
    localparam bit AUTO_EN = 1'b1;
`else
    localparam bit AUTO_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_MAX - 1);
    localparam logic [CNT_W-1:0] AUTO_LAST   = CNT_W'(AUTO_CLOSE - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             act_q;
    logic             last_up_q;   // 1 = last motion was UP, 0 = DOWN
    logic             act_edge;
    logic             auto_run;

    assign act_edge = Activate & ~act_q;
    // Any obstruction or button press restarts the auto-close wait.
    assign auto_run = AUTO_EN & UP_Max & ~Obstruct & ~act_edge;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            act_q     <= 1'b0;
            last_up_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            act_q   <= Activate;
            if (state_d == MV_UP)
                last_up_q <= 1'b1;
            else if (state_d == MV_DN)
                last_up_q <= 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        if (UP_Max && DN_Max) begin
            state_d = FLT;
        end else begin
            case (state_q)
                IDLE: begin
                    if (act_edge) begin
                        if (DN_Max)
                            state_d = MV_UP;
                        else if (UP_Max)
                            state_d = MV_DN;
                        else
                            state_d = last_up_q ? MV_DN : MV_UP;
                    end else if (auto_run && cnt_q == AUTO_LAST) begin
                        state_d = MV_DN;
                    end
                end
                MV_UP: begin
                    if (UP_Max || act_edge)
                        state_d = IDLE;
                    else if (cnt_q == TRAVEL_LAST)
                        state_d = FLT;
                end
                MV_DN: begin
                    if (DN_Max)
                        state_d = IDLE;
                    else if (Obstruct)
                        state_d = MV_UP;
                    else if (act_edge)
                        state_d = IDLE;
                    else if (cnt_q == TRAVEL_LAST)
                        state_d = FLT;
                end
                FLT: begin
                    if (act_edge)
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Shared cycle counter: cleared on any state change, saturating.
    always_comb begin
        cnt_d = '0;
        if (state_d == state_q) begin
            if (state_q == MV_UP || state_q == MV_DN ||
                (state_q == IDLE && auto_run)) begin
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
            end
        end
    end

    assign UP_M  = (state_q == MV_UP);
    assign DN_M  = (state_q == MV_DN);
    assign FAULT = (state_q == FLT);
    assign STATE = state_q;

endmodule

// File: tb/tb_garage_door_ctrl.sv
module tb_garage_door_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       Activate = 1'b0;
    logic       UP_Max = 1'b0;
    logic       DN_Max = 1'b0;
    logic       Obstruct = 1'b0;
    logic       UP_M, DN_M, FAULT;
    logic [1:0] STATE;

    int errors = 0;
    int checks = 0;
    bit done   = 1'b0;

    typedef struct {
        string      nm;
        logic [4:0] val;   // {UP_M, DN_M, FAULT, STATE}
    } exp_t;

    exp_t sb[$];

    garage_door_ctrl #(
        .TRAVEL_MAX(20),
        .AUTO_CLOSE(50),
        .CNT_W(16)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .Activate(Activate),
        .UP_Max(UP_Max),
        .DN_Max(DN_Max),
        .Obstruct(Obstruct),
        .UP_M(UP_M),
        .DN_M(DN_M),
        .FAULT(FAULT),
        .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    // Monitor: outputs are settled at the falling edge; compare every
    // expectation queued since the previous falling edge.
    initial begin
        exp_t e;
        logic [4:0] act;
        forever begin
            @(negedge CLK);
            while (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {UP_M, DN_M, FAULT, STATE};
                checks++;
                if (act !== e.val) begin
                    errors++;
                    $display("FAIL %s: got up=%b dn=%b flt=%b st=%0d, want up=%b dn=%b flt=%b st=%0d",
                             e.nm, act[4], act[3], act[2], act[1:0],
                             e.val[4], e.val[3], e.val[2], e.val[1:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_out(input string nm, input logic up, input logic dn,
                              input logic flt, input logic [1:0] st);
        exp_t e;
        e.nm  = nm;
        e.val = {up, dn, flt, st};
        sb.push_back(e);
    endtask

    initial begin
        // Reset state
        tick();
        expect_out("reset", 0, 0, 0, 0);
        tick();
        RST = 1'b1;
        DN_Max = 1'b1;
        tick();
        expect_out("closed_idle", 0, 0, 0, 0);

        // Held button from closed: one edge, opens, stops at top limit
        Activate = 1'b1;
        expect_out("act_pre", 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0) DN_Max = 1'b0;
            expect_out("hold_up", 1, 0, 0, 1);
        end
        Activate = 1'b0;
        tick();
        UP_Max = 1'b1;
        tick();
        expect_out("up_limit", 0, 0, 0, 0);

        // Watchdog: closing from open, no limit ever reached
        Activate = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 0) begin
                Activate = 1'b0;
                UP_Max = 1'b0;
            end
            expect_out("wd_dn", 0, 1, 0, 2);
        end
        tick();
        expect_out("wd_fault", 0, 0, 1, 3);
        tick();
        expect_out("fault_hold", 0, 0, 1, 3);
        Activate = 1'b1;
        tick();
        expect_out("fault_clear", 0, 0, 0, 0);
        Activate = 1'b0;
        tick();

        // Obstruction reverses a closing door; counter restarts in MV_UP
        UP_Max = 1'b1;
        Activate = 1'b1;
        tick();
        expect_out("obs_dn", 0, 1, 0, 2);
        Activate = 1'b0;
        UP_Max = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_out("obs_dn_run", 0, 1, 0, 2);
        end
        Obstruct = 1'b1;
        tick();
        expect_out("obs_reverse", 1, 0, 0, 1);
        for (int i = 0; i < 19; i++) begin
            // obstruction is ignored while opening
            Obstruct = (i < 3);
            tick();
            expect_out("obs_up_run", 1, 0, 0, 1);
        end
        Obstruct = 1'b0;
        tick();
        expect_out("obs_up_wd", 0, 0, 1, 3);
        Activate = 1'b1;
        tick();
        expect_out("fault_clear2", 0, 0, 0, 0);
        Activate = 1'b0;
        tick();

        // Mid-travel stop, then reverse direction from between limits
        DN_Max = 1'b1;
        Activate = 1'b1;
        tick();
        expect_out("mid_up", 1, 0, 0, 1);
        Activate = 1'b0;
        DN_Max = 1'b0;
        tick();
        tick();
        expect_out("mid_up_run", 1, 0, 0, 1);
        Activate = 1'b1;
        tick();
        expect_out("mid_stop", 0, 0, 0, 0);
        Activate = 1'b0;
        tick();
        expect_out("mid_stopped", 0, 0, 0, 0);
        Activate = 1'b1;
        tick();
        expect_out("mid_resume_dn", 0, 1, 0, 2);
        Activate = 1'b0;
        tick();
        DN_Max = 1'b1;
        tick();
        expect_out("dn_limit", 0, 0, 0, 0);

        // Both limits while opening -> fault; cannot clear while both high
        Activate = 1'b1;
        tick();
        expect_out("both_up", 1, 0, 0, 1);
        Activate = 1'b0;
        DN_Max = 1'b0;
        tick();
        UP_Max = 1'b1;
        DN_Max = 1'b1;
        tick();
        expect_out("both_limits", 0, 0, 1, 3);
        Activate = 1'b1;
        tick();
        expect_out("both_no_clear", 0, 0, 1, 3);
        Activate = 1'b0;
        UP_Max = 1'b0;
        DN_Max = 1'b0;
        tick();
        Activate = 1'b1;
        tick();
        expect_out("both_clear", 0, 0, 0, 0);
        Activate = 1'b0;
        tick();

        // Async reset mid-close (last direction was UP, so next is DOWN)
        Activate = 1'b1;
        tick();
        expect_out("pre_rst_dn", 0, 1, 0, 2);
        Activate = 1'b0;
        tick();
        RST = 1'b0;
        expect_out("rst_async", 0, 0, 0, 0);
        tick();
        RST = 1'b1;
        tick();
        // reset restores last_dir=DOWN, so an unlimited door now opens
        Activate = 1'b1;
        tick();
        expect_out("post_rst_up", 1, 0, 0, 1);
        Activate = 1'b0;
        tick();
        UP_Max = 1'b1;
        tick();
        expect_out("open_idle", 0, 0, 0, 0);

`ifdef GDC_AUTO_CLOSE_EN
        for (int i = 0; i < 30; i++) begin
            tick();
            expect_out("ac_wait1", 0, 0, 0, 0);
        end
        Obstruct = 1'b1;
        tick();
        expect_out("ac_obstruct", 0, 0, 0, 0);
        Obstruct = 1'b0;
        for (int i = 0; i < 49; i++) begin
            tick();
            expect_out("ac_wait2", 0, 0, 0, 0);
        end
        tick();
        expect_out("ac_close", 0, 1, 0, 2);
        UP_Max = 1'b0;
        DN_Max = 1'b1;
        tick();
        expect_out("ac_closed", 0, 0, 0, 0);
`else
        for (int i = 0; i < 100; i++) begin
            tick();
            expect_out("open_stays", 0, 0, 0, 0);
        end
`endif

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, want finish");
        $fatal(1);
    end

endmodule
